dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_arbiter_if.sv | 26 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding and memory geometry.
package dmem_pkg;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   localparam int MEM_BYTES_DEF = 41;
   localparam int WORD_BYTES    = 4;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters / data memory and the arbiter.
interface dmem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              req0, req1, we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              mem_mr, mem_mw;
   logic [ADDR_W-1:0] mem_add;
   logic [DATA_W-1:0] mem_wd, mem_data;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data,
      output gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy, rdata0, rdata1,
             mem_mr, mem_mw, mem_add, mem_wd
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data,
      input  gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy, rdata0, rdata1,
             mem_mr, mem_mw, mem_add, mem_wd
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the port that did not win last is chosen.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_en,
   input  logic       i_upd,
   output logic [1:0] o_gnt
);
   logic r_last;   // 1 when port 1 won the last accepted grant
   logic w_pick1;

   assign w_pick1 = i_req[1] & (~i_req[0] | ~r_last);
   assign o_gnt   = i_en ? {w_pick1, i_req[0] & ~w_pick1} : 2'b00;

   always_ff @(posedge clk) begin
      if (rst)
         r_last <= 1'b1;
      else if (i_upd)
         r_last <= o_gnt[1];
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU port and a DMA/debug port onto one single-cycle-strobe data memory.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);
   state_t                  r_state;
   logic                    r_sel, r_we;
   logic                    r_mr, r_mw;
   logic [ADDR_W-1:0]       r_mem_add;
   logic [DATA_W-1:0]       r_mem_wd;
   logic [1:0]              r_err, r_rvalid;
   logic [1:0][DATA_W-1:0]  r_rdata;

   logic [1:0]              w_req, w_gnt;
   logic                    w_en, w_grant, w_sel, w_we, w_oor, w_upd;
   logic [ADDR_W-1:0]       w_addr;
   logic [DATA_W-1:0]       w_wdata;
   logic [ADDR_W:0]         w_end;

   assign w_req   = {bus.req1, bus.req0};
   assign w_en    = (r_state == S_IDLE) & ~rst;
   assign w_grant = |w_gnt;
   assign w_sel   = w_gnt[1];
   assign w_we    = w_sel ? bus.we1    : bus.we0;
   assign w_addr  = w_sel ? bus.addr1  : bus.addr0;
   assign w_wdata = w_sel ? bus.wdata1 : bus.wdata0;

   // One extra bit so addresses near the top of the space cannot wrap into range.
   assign w_end   = {1'b0, w_addr} + (ADDR_W+1)'(WORD_BYTES - 1);
   assign w_oor   = w_end > (ADDR_W+1)'(MEM_BYTES - 1);
   assign w_upd   = w_grant & ~w_oor;

   rr_arb2 u_rr (
      .clk   (clk),
      .rst   (rst),
      .i_req (w_req),
      .i_en  (w_en),
      .i_upd (w_upd),
      .o_gnt (w_gnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_sel     <= 1'b0;
         r_we      <= 1'b0;
         r_mr      <= 1'b0;
         r_mw      <= 1'b0;
         r_mem_add <= '0;
         r_mem_wd  <= '0;
         r_err     <= '0;
         r_rvalid  <= '0;
         r_rdata   <= '0;
      end else begin
         r_mr     <= 1'b0;
         r_mw     <= 1'b0;
         r_err    <= '0;
         r_rvalid <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  if (w_oor) begin
                     r_err[w_sel] <= 1'b1;
                  end else begin
                     r_sel     <= w_sel;
                     r_we      <= w_we;
                     r_mem_add <= w_addr;
                     r_mem_wd  <= w_wdata;
                     r_mr      <= ~w_we;
                     r_mw      <= w_we;
                     r_state   <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: r_state <= r_we ? S_IDLE : S_RESP;
            S_RESP: begin
               // Memory returned the word one clock after the strobe; hand it to the owner.
               r_rdata[r_sel]  <= bus.mem_data;
               r_rvalid[r_sel] <= 1'b1;
               r_state         <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.gnt0    = w_gnt[0];
   assign bus.gnt1    = w_gnt[1];
   assign bus.err0    = r_err[0];
   assign bus.err1    = r_err[1];
   assign bus.rvalid0 = r_rvalid[0];
   assign bus.rvalid1 = r_rvalid[1];
   assign bus.rdata0  = r_rdata[0];
   assign bus.rdata1  = r_rdata[1];
   assign bus.busy    = (r_state != S_IDLE);
   assign bus.mem_mr  = r_mr;
   assign bus.mem_mw  = r_mw;
   assign bus.mem_add = r_mem_add;
   assign bus.mem_wd  = r_mem_wd;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: a transaction-level model predicts timed output events; a monitor matches them.
module tb_dmem_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MB = 41;

   typedef struct {
      int          cyc;
      int          kind;   // 0 gnt, 1 err, 2 mem_mr, 3 mem_mw, 4 rvalid
      int          port;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_BYTES(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0]  init_img [MB];
   logic [7:0]  smem     [MB];
   logic [7:0]  rmem     [MB];
   logic [31:0] oor_tbl  [4] = '{32'd38, 32'd40, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
   int          exp_order[4] = '{0, 1, 0, 1};
   string       kn[5] = '{"gnt", "err", "mem_mr", "mem_mw", "rvalid"};

   int          cyc = 0;
   int          total = 0, bad = 0;
   int          probe = 0, tmo = 0;
   bit          m_init = 0, r_init = 0, prev_rst = 0;
   int          free_at = 0, ptr_last = 1;
   logic [31:0] exp_rd [2];
   int          last_gnt [2], last_rv [2];
   int          glog [$];
   ev_t         q [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Attached data memory: big-endian word at the byte address, read data one clock after mem_mr.
   always @(posedge clk) begin
      if (!m_init) begin
         for (int i = 0; i < MB; i++) smem[i] <= init_img[i];
         m_init <= 1'b1;
      end else begin
         if (bus.mem_mr && bus.mem_add < 32'(MB - 3))
            bus.mem_data <= {smem[bus.mem_add], smem[bus.mem_add+1],
                             smem[bus.mem_add+2], smem[bus.mem_add+3]};
         if (bus.mem_mw && bus.mem_add < 32'(MB - 3)) begin
            smem[bus.mem_add]   <= bus.mem_wd[31:24];
            smem[bus.mem_add+1] <= bus.mem_wd[23:16];
            smem[bus.mem_add+2] <= bus.mem_wd[15:8];
            smem[bus.mem_add+3] <= bus.mem_wd[7:0];
         end
      end
   end

   function automatic void chk(string nm, bit ok, logic [63:0] act, logic [63:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endfunction

   function automatic int key(ev_t e);
      return e.cyc * 16 + e.kind * 2 + e.port;
   endfunction

   function automatic void push_ev(int c, int k, int p, logic [31:0] a, logic [31:0] d);
      ev_t e;
      int  i;
      e = '{c, k, p, a, d};
      i = 0;
      while (i < q.size() && key(q[i]) <= key(e)) i++;
      q.insert(i, e);
   endfunction

   function automatic bit pulse(int k, int p);
      case (k)
         0: return p ? bus.gnt1 : bus.gnt0;
         1: return p ? bus.err1 : bus.err0;
         2: return bus.mem_mr;
         3: return bus.mem_mw;
         default: return p ? bus.rvalid1 : bus.rvalid0;
      endcase
   endfunction

   // Reference model: serialised accesses, one word each, fixed per-kind occupancy.
   function automatic void predict();
      int          p, ia;
      bit          we;
      logic [31:0] a, d;
      if (cyc < free_at || !(bus.req0 || bus.req1)) return;
      if (bus.req0 && bus.req1) p = (ptr_last == 0) ? 1 : 0;
      else                      p = bus.req1 ? 1 : 0;
      we = p ? bus.we1    : bus.we0;
      a  = p ? bus.addr1  : bus.addr0;
      d  = p ? bus.wdata1 : bus.wdata0;
      push_ev(cyc, 0, p, 0, 0);
      if (longint'({32'h0, a}) + 3 > longint'(MB - 1)) begin
         push_ev(cyc + 1, 1, p, 0, 0);
         free_at = cyc + 1;
      end else begin
         ptr_last = p;
         ia = int'(a);
         if (we) begin
            push_ev(cyc + 1, 3, 0, a, d);
            rmem[ia] = d[31:24]; rmem[ia+1] = d[23:16]; rmem[ia+2] = d[15:8]; rmem[ia+3] = d[7:0];
            free_at = cyc + 2;
         end else begin
            push_ev(cyc + 1, 2, 0, a, 0);
            push_ev(cyc + 3, 4, p, 0, {rmem[ia], rmem[ia+1], rmem[ia+2], rmem[ia+3]});
            free_at = cyc + 3;
         end
      end
   endfunction

   always @(negedge clk) begin
      bit  obs, hit, ok;
      ev_t e;
      if (!r_init) begin
         for (int i = 0; i < MB; i++) rmem[i] = init_img[i];
         exp_rd[0] = '0; exp_rd[1] = '0;
         last_gnt[0] = -1; last_gnt[1] = -1; last_rv[0] = -2; last_rv[1] = -2;
         r_init = 1'b1;
      end
      if (prev_rst)
         chk("reset_outs",
             {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1, bus.busy,
              bus.mem_mr, bus.mem_mw} == 9'd0 &&
             (bus.rdata0 | bus.rdata1 | bus.mem_add | bus.mem_wd) == 32'd0,
             {23'd0, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1, bus.busy,
              bus.mem_mr, bus.mem_mw, bus.rdata0 | bus.rdata1 | bus.mem_add | bus.mem_wd}, 0);
      chk("busy", bus.busy == (cyc < free_at), 64'(bus.busy), 64'(cyc < free_at));
      if (!rst) predict();

      for (int k = 0; k < 5; k++) begin
         for (int p = 0; p < 2; p++) begin
            if ((k == 2 || k == 3) && p == 1) continue;
            while (q.size() > 0 && q[0].cyc < cyc) begin
               e = q.pop_front();
               chk($sformatf("stale_%s%0d", kn[e.kind], e.port), 1'b0, 64'(e.cyc), 64'(cyc));
            end
            obs = pulse(k, p);
            if (obs && k == 0) begin glog.push_back(p); last_gnt[p] = cyc; end
            if (obs && k == 4) last_rv[p] = cyc;
            hit = q.size() > 0 && q[0].cyc == cyc && q[0].kind == k && q[0].port == p;
            if (hit) begin
               e = q.pop_front();
               if (!obs) chk($sformatf("missing_%s%0d", kn[k], p), 1'b0, 0, 1);
               else begin
                  case (k)
                     2: chk("mem_rd_addr", bus.mem_add == e.a, 64'(bus.mem_add), 64'(e.a));
                     3: chk("mem_wr", bus.mem_add == e.a && bus.mem_wd == e.d,
                            {bus.mem_add, bus.mem_wd}, {e.a, e.d});
                     4: begin
                        ok = (p ? bus.rdata1 : bus.rdata0) == e.d;
                        chk($sformatf("rdata%0d", p), ok,
                            64'(p ? bus.rdata1 : bus.rdata0), 64'(e.d));
                     end
                     default: chk($sformatf("%s%0d", kn[k], p), 1'b1, 1, 1);
                  endcase
               end
               if (k == 4) exp_rd[p] = e.d;
            end else if (obs) begin
               chk($sformatf("unexpected_%s%0d", kn[k], p), 1'b0, 1, 0);
            end
         end
      end
      chk("rdata_hold", bus.rdata0 == exp_rd[0] && bus.rdata1 == exp_rd[1],
          {bus.rdata0, bus.rdata1}, {exp_rd[0], exp_rd[1]});

      case (probe)
         1: chk("single_rd_data", bus.rdata0 == 32'h2D00_0000, 64'(bus.rdata0), 64'h2D00_0000);
         2: chk("wr_then_rd_data", bus.rdata1 == 32'hDEAD_BEEF, 64'(bus.rdata1), 64'hDEAD_BEEF);
         3: begin
            ok = (glog.size() == 4);
            if (ok) for (int i = 0; i < 4; i++) ok &= (glog[i] == exp_order[i]);
            chk("contention_order", ok, 64'(glog.size()), 4);
         end
         4: chk("b2b_gnt1_at_rvalid0", last_gnt[1] == last_rv[0],
                64'(last_gnt[1]), 64'(last_rv[0]));
         5: begin
            chk("queue_drained", q.size() == 0, 64'(q.size()), 0);
            chk("req_timeout", tmo == 0, 64'(tmo), 0);
         end
         default: ;
      endcase

      if (rst) begin
         q.delete();
         glog.delete();
         free_at  = 0;
         ptr_last = 1;
         exp_rd[0] = '0; exp_rd[1] = '0;
      end
      prev_rst = rst;
   end

   task automatic set_req(input int p, input bit r, input bit we, input logic [31:0] a,
                          input logic [31:0] d);
      if (p == 0) begin bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
      else        begin bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
   endtask

   task automatic do_req(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
      int n;
      bit g;
      @(posedge clk); #1;
      set_req(p, 1'b1, we, a, d);
      n = 0;
      do begin
         @(negedge clk);
         g = p ? bus.gnt1 : bus.gnt0;
         n++;
      end while (!g && n < 100);
      if (!g) tmo++;
      @(posedge clk); #1;
      set_req(p, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic set_probe(input int id);
      @(posedge clk); #1 probe = id;
      @(posedge clk); #1 probe = 0;
   endtask

   task automatic rand_port(input int p);
      logic [31:0] a;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         if ($urandom_range(0, 9) == 0) a = oor_tbl[$urandom_range(0, 3)];
         else                           a = 32'($urandom_range(0, MB - 4));
         do_req(p, 1'($urandom_range(0, 1)), a, $urandom);
      end
   endtask

   initial begin
      rst = 1'b1;
      set_req(0, 1'b0, 1'b0, 0, 0);
      set_req(1, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < MB; i++) init_img[i] = 8'($urandom);
      init_img[16] = 8'd45; init_img[17] = 8'd0; init_img[18] = 8'd0; init_img[19] = 8'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      do_req(0, 1'b0, 32'd16, 32'd0);
      repeat (4) @(posedge clk);
      set_probe(1);

      do_req(1, 1'b1, 32'd4, 32'hDEAD_BEEF);
      do_req(1, 1'b0, 32'd4, 32'd0);
      repeat (4) @(posedge clk);
      set_probe(2);

      do_req(0, 1'b0, 32'd38, 32'd0);
      do_req(1, 1'b1, 32'hFFFF_FFFD, 32'h0BAD_0BAD);
      do_req(0, 1'b0, 32'd37, 32'd0);
      repeat (4) @(posedge clk);

      fork
         do_req(0, 1'b0, 32'd20, 32'd0);
         begin @(posedge clk); do_req(1, 1'b1, 32'd24, 32'h1234_5678); end
      join
      repeat (3) @(posedge clk);
      set_probe(4);

      // Abort a read while it waits for memory data.
      do_req(0, 1'b0, 32'd8, 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;

      fork
         begin do_req(0, 1'b1, 32'd0,  $urandom); do_req(0, 1'b1, 32'd12, $urandom); end
         begin do_req(1, 1'b1, 32'd28, $urandom); do_req(1, 1'b1, 32'd32, $urandom); end
      join
      repeat (2) @(posedge clk);
      set_probe(3);

      fork
         rand_port(0);
         rand_port(1);
      join
      repeat (6) @(posedge clk);
      set_probe(5);
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
